// File: rtl/mask_decimator.sv
// 4x4 block decimator for a thresholded video mask: one counter per decimated column, one output per block.
// Build option: MASK_DECIMATOR_MAJORITY_EN selects majority voting against THRESHOLD (default build uses logical OR).
module mask_decimator #(
  parameter int SRC_WIDTH  = 1280,
  parameter int SRC_HEIGHT = 720,
  parameter int THRESHOLD  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        mask_in,
  input  logic        valid_in,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic        mask_out,
  output logic        valid_out,
  output logic        new_frame_out,
  output logic [15:0] frame_mass_out
);

  localparam int          NCOL   = SRC_WIDTH / 4;
  localparam logic [10:0] SRC_W  = 11'(SRC_WIDTH);
  localparam logic [9:0]  SRC_H  = 10'(SRC_HEIGHT);
  localparam logic [8:0]  LAST_X = 9'(SRC_WIDTH / 4 - 1);
  localparam logic [7:0]  LAST_Y = 8'(SRC_HEIGHT / 4 - 1);
`ifdef MASK_DECIMATOR_MAJORITY_EN
  localparam logic [4:0]  THR    = 5'(THRESHOLD);
`endif

  logic [4:0]  cnt_q [NCOL];
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        mask_q, mask_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        new_frame_q, new_frame_d;
  logic [15:0] frame_mass_q, frame_mass_d;
  logic [15:0] acc_q, acc_d;

  logic        accept_s;
  logic        first_s;
  logic        emit_s;
  logic        hit_s;
  logic [8:0]  col_s;
  logic [4:0]  base_s;
  logic [4:0]  sum_s;
  logic [4:0]  cnt_d;
  logic [15:0] acc_base_s;

  always_comb begin
    accept_s = valid_in && (hcount_in < SRC_W) && (vcount_in < SRC_H);
    col_s    = hcount_in[10:2];
    first_s  = (hcount_in[1:0] == 2'd0) && (vcount_in[1:0] == 2'd0);
    emit_s   = accept_s && (hcount_in[1:0] == 2'd3) && (vcount_in[1:0] == 2'd3);

    // The block's first sub-pixel restarts the count instead of adding to stale data.
    base_s = first_s ? 5'd0 : cnt_q[col_s];
    sum_s  = base_s + {4'd0, mask_in};
    cnt_d  = (sum_s > 5'd16) ? 5'd16 : sum_s;

`ifdef MASK_DECIMATOR_MAJORITY_EN
    hit_s = (cnt_d >= THR);
`else
    hit_s = (cnt_d != 5'd0);
`endif

    valid_d     = emit_s;
    x_d         = emit_s ? col_s : x_q;
    y_d         = emit_s ? vcount_in[9:2] : y_q;
    mask_d      = emit_s ? hit_s : mask_q;
    last_d      = emit_s && (col_s == LAST_X) && (vcount_in[9:2] == LAST_Y);
    new_frame_d = valid_q && last_q;

    // The accumulator already holds the final block's contribution when the frame closes.
    frame_mass_d = new_frame_d ? acc_q : frame_mass_q;
    acc_base_s   = new_frame_d ? 16'd0 : acc_q;
    if (accept_s && (hcount_in == 11'd0) && (vcount_in == 10'd0)) begin
      acc_d = 16'd0;
    end else if (emit_s && hit_s && (acc_base_s != 16'hFFFF)) begin
      acc_d = acc_base_s + 16'd1;
    end else begin
      acc_d = acc_base_s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NCOL; i++) begin
        cnt_q[i] <= 5'd0;
      end
      x_q          <= 9'd0;
      y_q          <= 8'd0;
      mask_q       <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      new_frame_q  <= 1'b0;
      frame_mass_q <= 16'd0;
      acc_q        <= 16'd0;
    end else begin
      if (accept_s) begin
        cnt_q[col_s] <= cnt_d;
      end
      x_q          <= x_d;
      y_q          <= y_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      new_frame_q  <= new_frame_d;
      frame_mass_q <= frame_mass_d;
      acc_q        <= acc_d;
    end
  end

  assign x_out          = x_q;
  assign y_out          = y_q;
  assign mask_out       = mask_q;
  assign valid_out      = valid_q;
  assign new_frame_out  = new_frame_q;
  assign frame_mass_out = frame_mass_q;

endmodule

// File: tb/tb_mask_decimator.sv
// Directed bench for mask_decimator on a reduced 16x12 source (4x3 decimated blocks).
module tb_mask_decimator;

  localparam int W   = 16;
  localparam int H   = 12;
  localparam int THR = 8;
`ifdef MASK_DECIMATOR_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic        mask_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic        mask_out;
  logic        valid_out;
  logic        new_frame_out;
  logic [15:0] frame_mass_out;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_set = 0;
  int n_nf = 0;
  logic mmap [12];

  mask_decimator #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .mask_in(mask_in), .valid_in(valid_in), .x_out(x_out), .y_out(y_out),
    .mask_out(mask_out), .valid_out(valid_out), .new_frame_out(new_frame_out),
    .frame_mass_out(frame_mass_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (valid_out) begin
      n_valid <= n_valid + 1;
      if (mask_out) n_set <= n_set + 1;
      if ((int'(y_out) * 4 + int'(x_out)) < 12) mmap[int'(y_out) * 4 + int'(x_out)] <= mask_out;
    end
    if (new_frame_out) n_nf <= n_nf + 1;
  end

  function automatic bit exp_hit(input int n);
    return MAJ ? (n >= THR) : (n >= 1);
  endfunction

  // pat 0: zeros, 1: ones, 2: first n sub-pixels of block (0,0), 3: only the last source pixel
  function automatic bit pix_mask(input int pat, input int n, input int h, input int v);
    case (pat)
      0: return 1'b0;
      1: return 1'b1;
      2: return (h < 4) && (v < 4) && ((v * 4 + h) < n);
      3: return (h == W - 1) && (v == H - 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input int h, input int v, input bit m);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    mask_in   = m;
    valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_lines(input int pat, input int n, input int v0, input int v1, input bit gaps);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < W; h++) begin
        send(h, v, pix_mask(pat, n, h, v));
        if (gaps) begin
          valid_in = 1'b0;
          mask_in  = 1'b1;
          @(posedge clk_in);
          #1;
        end
      end
      if (gaps) begin
        send(W + 4, v, 1'b1);
        send(3, H + 3, 1'b1);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (new_frame_out !== 1'b0) begin errors++; $display("FAIL reset_nf: got %b expected 0", new_frame_out); end
    checks++; if (mask_out !== 1'b0) begin errors++; $display("FAIL reset_mask: got %b expected 0", mask_out); end
    checks++; if (x_out !== 9'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x_out); end
    checks++; if (y_out !== 8'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y_out); end
    checks++; if (frame_mass_out !== 16'd0) begin errors++; $display("FAIL reset_mass: got %0d expected 0", frame_mass_out); end
    rst_in = 1'b1;
    idle(2);
  endtask

  task automatic test_all_ones();
    int sv, ss, sn;
    sv = n_valid; ss = n_set; sn = n_nf;
    send_lines(1, 0, 0, H - 1, 1'b0);
    idle(3);
    checks++; if (n_valid - sv !== 12) begin errors++; $display("FAIL ones_valid: got %0d expected 12", n_valid - sv); end
    checks++; if (n_set - ss !== 12) begin errors++; $display("FAIL ones_set: got %0d expected 12", n_set - ss); end
    checks++; if (n_nf - sn !== 1) begin errors++; $display("FAIL ones_nf: got %0d expected 1", n_nf - sn); end
    checks++; if (frame_mass_out !== 16'd12) begin errors++; $display("FAIL ones_mass: got %0d expected 12", frame_mass_out); end
    checks++; if (x_out !== 9'd3 || y_out !== 8'd2) begin errors++; $display("FAIL ones_last_xy: got %0d,%0d expected 3,2", x_out, y_out); end
  endtask

  task automatic test_threshold();
    int counts [3] = '{8, 7, 1};
    for (int k = 0; k < 3; k++) begin
      int sv;
      sv = n_valid;
      send_lines(2, counts[k], 0, H - 1, 1'b0);
      idle(3);
      checks++; if (n_valid - sv !== 12) begin errors++; $display("FAIL thr%0d_valid: got %0d expected 12", counts[k], n_valid - sv); end
      checks++; if (mmap[0] !== exp_hit(counts[k])) begin errors++; $display("FAIL thr%0d_mask00: got %b expected %b", counts[k], mmap[0], exp_hit(counts[k])); end
      checks++; if (frame_mass_out !== 16'(exp_hit(counts[k]))) begin errors++; $display("FAIL thr%0d_mass: got %0d expected %0d", counts[k], frame_mass_out, exp_hit(counts[k])); end
    end
  endtask

  task automatic test_single_last();
    send_lines(3, 0, 0, H - 1, 1'b0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL last_valid: got %b expected 1", valid_out); end
    checks++; if (x_out !== 9'd3 || y_out !== 8'd2) begin errors++; $display("FAIL last_xy: got %0d,%0d expected 3,2", x_out, y_out); end
    checks++; if (mask_out !== exp_hit(1)) begin errors++; $display("FAIL last_mask: got %b expected %b", mask_out, exp_hit(1)); end
    checks++; if (new_frame_out !== 1'b0) begin errors++; $display("FAIL last_nf_early: got %b expected 0", new_frame_out); end
    idle(1);
    checks++; if (new_frame_out !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL last_nf: got nf=%b valid=%b expected nf=1 valid=0", new_frame_out, valid_out); end
    checks++; if (frame_mass_out !== 16'(exp_hit(1))) begin errors++; $display("FAIL last_mass: got %0d expected %0d", frame_mass_out, exp_hit(1)); end
    checks++; if (x_out !== 9'd3 || y_out !== 8'd2) begin errors++; $display("FAIL last_hold_xy: got %0d,%0d expected 3,2", x_out, y_out); end
    idle(1);
    checks++; if (new_frame_out !== 1'b0) begin errors++; $display("FAIL last_nf_pulse: got %b expected 0", new_frame_out); end
  endtask

  task automatic test_gaps();
    int sv, ss, sn;
    sv = n_valid; ss = n_set; sn = n_nf;
    send_lines(0, 0, 0, H - 1, 1'b1);
    idle(3);
    checks++; if (n_valid - sv !== 12) begin errors++; $display("FAIL gap0_valid: got %0d expected 12", n_valid - sv); end
    checks++; if (n_set - ss !== 0) begin errors++; $display("FAIL gap0_set: got %0d expected 0", n_set - ss); end
    checks++; if (n_nf - sn !== 1) begin errors++; $display("FAIL gap0_nf: got %0d expected 1", n_nf - sn); end
    checks++; if (frame_mass_out !== 16'd0) begin errors++; $display("FAIL gap0_mass: got %0d expected 0", frame_mass_out); end
    sv = n_valid; ss = n_set; sn = n_nf;
    send_lines(1, 0, 0, H - 1, 1'b1);
    idle(3);
    checks++; if (n_valid - sv !== 12) begin errors++; $display("FAIL gap1_valid: got %0d expected 12", n_valid - sv); end
    checks++; if (n_set - ss !== 12) begin errors++; $display("FAIL gap1_set: got %0d expected 12", n_set - ss); end
    checks++; if (n_nf - sn !== 1) begin errors++; $display("FAIL gap1_nf: got %0d expected 1", n_nf - sn); end
    checks++; if (frame_mass_out !== 16'd12) begin errors++; $display("FAIL gap1_mass: got %0d expected 12", frame_mass_out); end
  endtask

  task automatic test_reset_mid();
    int sv, ss, sn;
    send_lines(1, 0, 0, 6, 1'b0);
    for (int h = 0; h < 4; h++) send(h, 7, 1'b1);
    rst_in = 1'b0;
    send(7, 7, 1'b1);
    rst_in = 1'b1;
    checks++; if (valid_out !== 1'b0 || new_frame_out !== 1'b0 || mask_out !== 1'b0) begin errors++; $display("FAIL midrst_flags: got v=%b nf=%b m=%b expected 0,0,0", valid_out, new_frame_out, mask_out); end
    checks++; if (x_out !== 9'd0 || y_out !== 8'd0) begin errors++; $display("FAIL midrst_xy: got %0d,%0d expected 0,0", x_out, y_out); end
    checks++; if (frame_mass_out !== 16'd0) begin errors++; $display("FAIL midrst_mass: got %0d expected 0", frame_mass_out); end
    sv = n_valid; ss = n_set; sn = n_nf;
    for (int h = 8; h < W; h++) send(h, 7, 1'b0);
    send_lines(0, 0, 8, H - 1, 1'b0);
    idle(3);
    checks++; if (n_valid - sv !== 6) begin errors++; $display("FAIL midrst_valid: got %0d expected 6", n_valid - sv); end
    checks++; if (n_set - ss !== 0) begin errors++; $display("FAIL midrst_set: got %0d expected 0", n_set - ss); end
    checks++; if (n_nf - sn !== 1 || frame_mass_out !== 16'd0) begin errors++; $display("FAIL midrst_nf_mass: got nf=%0d mass=%0d expected 1,0", n_nf - sn, frame_mass_out); end
    send_lines(1, 0, 0, H - 1, 1'b0);
    idle(3);
    checks++; if (frame_mass_out !== 16'd12) begin errors++; $display("FAIL midrst_next_mass: got %0d expected 12", frame_mass_out); end
  endtask

  task automatic test_abort();
    int sn;
    sn = n_nf;
    send_lines(1, 0, 0, 7, 1'b0);
    send(0, 0, 1'b1);
    checks++; if (frame_mass_out !== 16'd12) begin errors++; $display("FAIL abort_mass_hold: got %0d expected 12", frame_mass_out); end
    send_lines(2, 8, 0, H - 1, 1'b0);
    idle(3);
    checks++; if (n_nf - sn !== 1) begin errors++; $display("FAIL abort_nf: got %0d expected 1", n_nf - sn); end
    checks++; if (frame_mass_out !== 16'd1) begin errors++; $display("FAIL abort_mass: got %0d expected 1", frame_mass_out); end
  endtask

  task automatic test_duplicate();
    send(0, 0, 1'b1);
    for (int i = 0; i < 30; i++) send(1, 0, 1'b1);
    send(3, 3, 1'b1);
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b1 || x_out !== 9'd0 || y_out !== 8'd0) begin errors++; $display("FAIL dup_emit: got v=%b x=%0d y=%0d expected 1,0,0", valid_out, x_out, y_out); end
    checks++; if (mask_out !== 1'b1) begin errors++; $display("FAIL dup_sat_mask: got %b expected 1", mask_out); end
    idle(1);
    checks++; if (new_frame_out !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL dup_after: got nf=%b v=%b expected 0,0", new_frame_out, valid_out); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_threshold();
    test_single_last();
    test_gaps();
    test_reset_mid();
    test_abort();
    test_duplicate();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
